dm_cache: RTL and testbench
===========================

DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 SHALL provide parameter ADDR_W, default 30, processor word-address width.
REQ-002 SHALL provide parameter DATA_W, default 32, word width in bits.
REQ-003 SHALL provide parameter WORDS, default 4, words per block (power of 2, >=2).
REQ-004 SHALL provide parameter LINES, default 8, number of lines (power of 2, >=2); derived OFS_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFS_W.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port proc_read  input  1  processor read request.
REQ-008 SHALL have port proc_write  input  1  processor write request.
REQ-009 SHALL have port proc_addr  input  ADDR_W  processor word address {tag,index,offset}.
REQ-010 SHALL have port proc_wdata  input  DATA_W  processor write data.
REQ-011 SHALL have port proc_rdata  output  DATA_W  read data, valid when proc_stall=0.
REQ-012 SHALL have port proc_stall  output  1  request not complete this cycle.
REQ-013 SHALL have port mem_read  output  1  block read request to memory.
REQ-014 SHALL have port mem_write  output  1  block write request to memory.
REQ-015 SHALL have port mem_addr  output  ADDR_W-OFS_W  block address.
REQ-016 SHALL have port mem_wdata  output  DATA_W*WORDS  write-back block.
REQ-017 SHALL have port mem_rdata  input  DATA_W*WORDS  refill block, word 0 in LSBs.
REQ-018 SHALL have port mem_ready  input  1  memory completed current request (one-cycle pulse).

Function
REQ-019 SHALL be direct-mapped, write-back, write-allocate; per line: valid, dirty, tag, WORDS data words.
REQ-020 SHALL implement FSM states COMPARE, WRITEBACK, ALLOCATE, REFILL.
REQ-021 COMPARE, hit (valid and tag match), read: proc_rdata=selected word combinationally, proc_stall=0, zero-wait.
REQ-022 COMPARE, write hit: proc_stall=0, word updated and dirty=1 at next rising edge.
REQ-023 COMPARE, miss with no request (neither read nor write): proc_stall=0, no state change.
REQ-024 COMPARE, miss with request: proc_stall=1 same cycle; next state WRITEBACK if victim valid and dirty, else ALLOCATE.
REQ-025 WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block, held stable until mem_ready; on mem_ready go ALLOCATE.
REQ-026 ALLOCATE: mem_read=1, mem_addr={proc tag,index}, held until mem_ready; on mem_ready capture mem_rdata into line, valid=1, dirty=0, tag=proc tag, go REFILL.
REQ-027 REFILL: proc_stall=1, no memory request; next cycle COMPARE, where request now hits (miss latency = memory cycles + 2).
REQ-028 mem_read and mem_write SHALL never be asserted together; both 0 outside WRITEBACK/ALLOCATE.
REQ-029 proc_stall SHALL be 1 in every state except COMPARE-hit or COMPARE-idle.
REQ-030 proc_read and proc_write both 1: SHALL be treated as write.
REQ-031 Processor SHALL hold request/address/data stable while proc_stall=1; cache behaviour is undefined otherwise.
REQ-032 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-033 Index conflict (same index, different tag) SHALL evict victim per REQ-024; same-block accesses after refill SHALL all hit.
REQ-034 Write miss SHALL refill full block first, then merge word in COMPARE (REQ-022).

Reset
REQ-035 rst_n=0 SHALL immediately force state COMPARE, all valid and dirty bits 0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0 when no request; data/tag arrays need not be cleared.
REQ-036 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abort the transfer; dirty data is lost, no partial line update.
REQ-037 First request after reset release SHALL miss.

Verification
REQ-038 Reset, read addr 0x00 with memory block 0 = {4,3,2,1} words, 3-cycle memory -> mem_read once at block addr 0, stall 5 cycles, then proc_rdata=1.
REQ-039 After REQ-038, read addrs 0x01..0x03 -> each zero-wait, proc_rdata=2,3,4, no mem_read.
REQ-040 Write 0x02 data 0xAA (hit) then read 0x20 (same index, defaults) -> mem_write with block addr 0, mem_wdata={4,0xAA,2,1}, then mem_read block addr 8.
REQ-041 Write miss to 0x45 data 0x55 on clean line -> ALLOCATE only, no mem_write; read 0x45 -> 0x55, dirty=1.
REQ-042 Assert rst_n=0 during ALLOCATE -> mem_read drops asynchronously; re-read same address -> full miss again.
REQ-043 proc_read and proc_write together on hit addr 0x01 data 0x77 -> write performed; subsequent read returns 0x77.

Source files
------------

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate cache.
//
// Each line holds a valid bit, a dirty bit, a tag and WORDS data words.
// The processor address is split as {tag, index, offset}. Hits complete
// with no wait states. A miss first writes back a dirty victim, then
// fetches the whole block, and then spends one REFILL cycle before the
// request is retried in COMPARE, where it now hits.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   proc_read/proc_write  processor request; both set is treated as a write
//   proc_addr/proc_wdata  processor word address and write data
//   proc_rdata            read data, valid while proc_stall is low
//   proc_stall            request is not complete this cycle
//   mem_read/mem_write    block request to memory, never both at once
//   mem_addr/mem_wdata    block address and write-back block
//   mem_rdata/mem_ready   refill block (word 0 in LSBs) and one-cycle done pulse
module dm_cache #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int WORDS  = 4,
   parameter int LINES  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         proc_read,
   input  logic                         proc_write,
   input  logic [ADDR_W-1:0]            proc_addr,
   input  logic [DATA_W-1:0]            proc_wdata,
   output logic [DATA_W-1:0]            proc_rdata,
   output logic                         proc_stall,
   output logic                         mem_read,
   output logic                         mem_write,
   output logic [ADDR_W-$clog2(WORDS)-1:0] mem_addr,
   output logic [DATA_W*WORDS-1:0]      mem_wdata,
   input  logic [DATA_W*WORDS-1:0]      mem_rdata,
   input  logic                         mem_ready
);

   localparam int OFS_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFS_W;

   typedef enum logic [1:0] {
      COMPARE   = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REFILL    = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_s;

   logic [LINES-1:0]  valid_r;
   logic [LINES-1:0]  dirty_r;
   logic [TAG_W-1:0]  tag_r  [LINES];
   logic [DATA_W-1:0] data_r [LINES][WORDS];

   logic [TAG_W-1:0]  ptag_s;
   logic [IDX_W-1:0]  idx_s;
   logic [OFS_W-1:0]  ofs_s;
   logic              hit_s;
   logic              req_s;
   logic              fill_s;
   logic              wr_hit_s;

   assign {ptag_s, idx_s, ofs_s} = proc_addr;
   assign hit_s = valid_r[idx_s] && (tag_r[idx_s] == ptag_s);
   assign req_s = proc_read | proc_write;

   // State register; reset aborts any memory transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= COMPARE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and all outputs, decoded from the current state.
   always_comb begin
      state_s    = state_r;
      proc_stall = 1'b1;
      proc_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_s     = 1'b0;
      wr_hit_s   = 1'b0;
      case (state_r)
         COMPARE: begin
            if (hit_s) begin
               proc_stall = 1'b0;
               if (proc_write) begin
                  wr_hit_s = 1'b1;
               end else if (proc_read) begin
                  proc_rdata = data_r[idx_s][ofs_s];
               end else begin
                  proc_rdata = '0;
               end
            end else if (!req_s) begin
               proc_stall = 1'b0;
            end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
               state_s = WRITEBACK;
            end else begin
               state_s = ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {tag_r[idx_s], idx_s};
            for (int w = 0; w < WORDS; w++) begin
               mem_wdata[w*DATA_W +: DATA_W] = data_r[idx_s][w];
            end
            if (mem_ready) begin
               state_s = ALLOCATE;
            end else begin
               state_s = WRITEBACK;
            end
         end
         ALLOCATE: begin
            mem_read = 1'b1;
            mem_addr = {ptag_s, idx_s};
            if (mem_ready) begin
               fill_s  = 1'b1;
               state_s = REFILL;
            end else begin
               state_s = ALLOCATE;
            end
         end
         REFILL: begin
            state_s = COMPARE;
         end
         default: begin
            state_s = COMPARE;
         end
      endcase
   end

   // Line status bits: set on refill, dirty on a write hit, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         dirty_r <= '0;
      end else if (fill_s) begin
         valid_r[idx_s] <= 1'b1;
         dirty_r[idx_s] <= 1'b0;
      end else if (wr_hit_s) begin
         dirty_r[idx_s] <= 1'b1;
      end else begin
         dirty_r <= dirty_r;
      end
   end

   // Tag and data arrays; not reset, since valid bits gate their use.
   always_ff @(posedge clk) begin
      if (fill_s) begin
         tag_r[idx_s] <= ptag_s;
         for (int w = 0; w < WORDS; w++) begin
            data_r[idx_s][w] <= mem_rdata[w*DATA_W +: DATA_W];
         end
      end else if (wr_hit_s) begin
         data_r[idx_s][ofs_s] <= proc_wdata;
      end
   end

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed scenarios followed by random
// accesses, compared against a line-level cache model and a flat memory
// image of what the processor should observe.
module tb_dm_cache;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int WD = 4;
   localparam int LN = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           proc_read = 1'b0;
   logic           proc_write = 1'b0;
   logic [AW-1:0]  proc_addr = '0;
   logic [DW-1:0]  proc_wdata = '0;
   logic [DW-1:0]  proc_rdata;
   logic           proc_stall;
   logic           mem_read;
   logic           mem_write;
   logic [AW-3:0]  mem_addr;
   logic [127:0]   mem_wdata;
   logic [127:0]   mem_rdata = '0;
   logic           mem_ready = 1'b0;

   dm_cache #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WD), .LINES(LN)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write),
      .proc_addr(proc_addr), .proc_wdata(proc_wdata),
      .proc_rdata(proc_rdata), .proc_stall(proc_stall),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // External memory contents and the value the processor should observe.
   logic [31:0] envmem [0:1023];
   logic [31:0] vis    [0:1023];
   // Model of which block each line holds.
   bit mv [LN];
   bit md [LN];
   int mt [LN];

   int lat = 3;
   int cnt = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int last_rd_addr = -1;
   int last_wr_addr = -1;
   logic [127:0] last_wr_data = '0;

   // Memory responder: completes each request after lat cycles.
   always @(negedge clk) begin
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
         checks++;
         if (mem_read && mem_write) begin
            errors++;
            $display("FAIL mem_excl: mem_read=%b mem_write=%b, required not both 1", mem_read, mem_write);
         end
         if (cnt >= lat - 1) begin
            mem_ready = 1'b1;
            cnt = 0;
            if (mem_write) begin
               for (int w = 0; w < 4; w++) envmem[int'(mem_addr)*4 + w] = mem_wdata[w*32 +: 32];
               wr_cnt++;
               last_wr_addr = int'(mem_addr);
               last_wr_data = mem_wdata;
            end else begin
               for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = envmem[int'(mem_addr)*4 + w];
               rd_cnt++;
               last_rd_addr = int'(mem_addr);
            end
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
      end
   end

   task automatic model_reset;
      for (int i = 0; i < LN; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
      for (int i = 0; i < 1024; i++) vis[i] = envmem[i];
   endtask

   // Predicts stall cycles, write-back and read data for one access.
   task automatic model_access(input bit wr, input int addr, input logic [31:0] wd,
                               output int exp_st, output bit exp_wb, output int ev_blk,
                               output logic [31:0] exp_rd);
      int idx;
      int tag;
      idx = (addr / 4) % LN;
      tag = addr / (4 * LN);
      exp_st = 0;
      exp_wb = 1'b0;
      ev_blk = -1;
      if (!(mv[idx] && mt[idx] == tag)) begin
         exp_wb = mv[idx] && md[idx];
         ev_blk = mt[idx] * LN + idx;
         exp_st = lat + 2 + (exp_wb ? lat : 0);
         mv[idx] = 1'b1;
         md[idx] = 1'b0;
         mt[idx] = tag;
      end
      if (wr) begin
         vis[addr] = wd;
         md[idx] = 1'b1;
      end
      exp_rd = vis[addr];
   endtask

   // Drives one request until it completes; returns observations and predictions.
   task automatic access(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                         output int st, output logic [31:0] got,
                         output int exp_st, output bit exp_wb, output int ev_blk,
                         output logic [31:0] exp_rd);
      model_access(wr, addr, wd, exp_st, exp_wb, ev_blk, exp_rd);
      @(negedge clk);
      proc_read = rd;
      proc_write = wr;
      proc_addr = AW'(addr);
      proc_wdata = wd;
      #1;
      st = 0;
      while (proc_stall && st < 100) begin
         st++;
         @(negedge clk);
         #1;
      end
      got = proc_rdata;
      @(posedge clk);
      #1;
      proc_read = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_read, mem_write, proc_stall} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: rd/wr/stall=%b, required 000", {mem_read, mem_write, proc_stall});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0 || proc_rdata !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required 0", mem_addr, mem_wdata, proc_rdata);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_refill;
      int st, es, ev, rd0;
      bit ewb;
      logic [31:0] got, erd;
      lat = 3;
      rd0 = rd_cnt;
      access(1'b1, 1'b0, 0, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 5) begin errors++; $display("FAIL refill_stall: got %0d, required 5", st); end
      checks++;
      if (got !== 32'd1) begin errors++; $display("FAIL refill_data: got %h, required 1", got); end
      checks++;
      if (rd_cnt !== rd0 + 1 || last_rd_addr !== 0) begin
         errors++;
         $display("FAIL refill_mem: reads %0d addr %0d, required %0d addr 0", rd_cnt - rd0, last_rd_addr, 1);
      end
   endtask

   task automatic test_hits;
      int st, es, ev, rd0;
      bit ewb;
      logic [31:0] got, erd;
      rd0 = rd_cnt;
      for (int a = 1; a < 4; a++) begin
         access(1'b1, 1'b0, a, 32'h0, st, got, es, ewb, ev, erd);
         checks++;
         if (st !== 0 || got !== 32'(a + 1)) begin
            errors++;
            $display("FAIL hit_read: addr %0d stall %0d data %h, required 0 and %h", a, st, got, a + 1);
         end
      end
      checks++;
      if (rd_cnt !== rd0) begin errors++; $display("FAIL hit_nomem: reads %0d, required 0", rd_cnt - rd0); end
   endtask

   task automatic test_evict;
      int st, es, ev, wr0;
      bit ewb;
      logic [31:0] got, erd;
      access(1'b0, 1'b1, 2, 32'hAA, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 0) begin errors++; $display("FAIL write_hit: stall %0d, required 0", st); end
      wr0 = wr_cnt;
      access(1'b1, 1'b0, 32'h20, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 8 || got !== envmem[32'h20]) begin
         errors++;
         $display("FAIL evict_read: stall %0d data %h, required 8 and %h", st, got, envmem[32'h20]);
      end
      checks++;
      if (wr_cnt !== wr0 + 1 || last_wr_addr !== 0 ||
          last_wr_data !== {32'd4, 32'hAA, 32'd2, 32'd1}) begin
         errors++;
         $display("FAIL evict_wb: writes %0d addr %0d data %h, required 1 addr 0 data 00000004000000aa0000000200000001",
                  wr_cnt - wr0, last_wr_addr, last_wr_data);
      end
      checks++;
      if (last_rd_addr !== 8) begin errors++; $display("FAIL evict_alloc: addr %0d, required 8", last_rd_addr); end
   endtask

   task automatic test_write_miss;
      int st, es, ev, wr0;
      bit ewb;
      logic [31:0] got, erd;
      wr0 = wr_cnt;
      access(1'b0, 1'b1, 32'h45, 32'h55, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 5 || wr_cnt !== wr0 || last_rd_addr !== 17) begin
         errors++;
         $display("FAIL wmiss: stall %0d writes %0d alloc %0d, required 5, 0, 17", st, wr_cnt - wr0, last_rd_addr);
      end
      access(1'b1, 1'b0, 32'h45, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 0 || got !== 32'h55) begin
         errors++;
         $display("FAIL wmiss_read: stall %0d data %h, required 0 and 55", st, got);
      end
      access(1'b1, 1'b0, 32'h65, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 8 || wr_cnt !== wr0 + 1 || last_wr_addr !== 17 || envmem[32'h45] !== 32'h55) begin
         errors++;
         $display("FAIL wmiss_dirty: stall %0d writes %0d addr %0d mem %h, required 8, 1, 17, 55",
                  st, wr_cnt - wr0, last_wr_addr, envmem[32'h45]);
      end
   endtask

   task automatic test_idle;
      int rd0;
      rd0 = rd_cnt;
      @(negedge clk);
      proc_addr = AW'(32'hC4);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL idle_miss: stall %b mem_read %b, required 0 0", proc_stall, mem_read);
         end
         @(negedge clk);
      end
      checks++;
      if (rd_cnt !== rd0) begin errors++; $display("FAIL idle_nomem: reads %0d, required 0", rd_cnt - rd0); end
   endtask

   task automatic test_reset_alloc;
      int st, es, ev, rd0;
      bit ewb;
      logic [31:0] got, erd;
      lat = 3;
      rd0 = rd_cnt;
      @(negedge clk);
      proc_read = 1'b1;
      proc_addr = AW'(32'h80);
      @(negedge clk);
      #1;
      checks++;
      if (mem_read !== 1'b1) begin errors++; $display("FAIL abort_pre: mem_read %b, required 1", mem_read); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL abort_async: mem_read %b addr %h, required 0 0", mem_read, mem_addr);
      end
      @(negedge clk);
      proc_read = 1'b0;
      rst_n = 1'b1;
      model_reset();
      checks++;
      if (rd_cnt !== rd0) begin errors++; $display("FAIL abort_count: reads %0d, required 0", rd_cnt - rd0); end
      access(1'b1, 1'b0, 32'h80, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 5 || rd_cnt !== rd0 + 1 || got !== envmem[32'h80]) begin
         errors++;
         $display("FAIL abort_remiss: stall %0d reads %0d data %h, required 5, 1, %h",
                  st, rd_cnt - rd0, got, envmem[32'h80]);
      end
   endtask

   task automatic test_rw_both;
      int st, es, ev;
      bit ewb;
      logic [31:0] got, erd;
      access(1'b1, 1'b0, 1, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 5) begin errors++; $display("FAIL rw_prep: stall %0d, required 5", st); end
      access(1'b1, 1'b1, 1, 32'h77, st, got, es, ewb, ev, erd);
      checks++;
      if (st !== 0) begin errors++; $display("FAIL rw_both: stall %0d, required 0", st); end
      access(1'b1, 1'b0, 1, 32'h0, st, got, es, ewb, ev, erd);
      checks++;
      if (got !== 32'h77) begin errors++; $display("FAIL rw_read: data %h, required 77", got); end
   endtask

   task automatic test_random;
      int st, es, ev, wr0, rd0, addr, op;
      bit ewb, rd, wr;
      logic [31:0] got, erd, wd;
      for (int n = 0; n < 300; n++) begin
         lat = $urandom_range(1, 4);
         addr = $urandom_range(0, 255);
         op = $urandom_range(0, 2);
         rd = (op != 1);
         wr = (op != 0);
         wd = $urandom;
         wr0 = wr_cnt;
         rd0 = rd_cnt;
         access(rd, wr, addr, wd, st, got, es, ewb, ev, erd);
         checks++;
         if (st !== es) begin errors++; $display("FAIL rnd_stall: addr %h stall %0d, required %0d", addr, st, es); end
         if (rd && !wr) begin
            checks++;
            if (got !== erd) begin errors++; $display("FAIL rnd_data: addr %h data %h, required %h", addr, got, erd); end
         end
         checks++;
         if (wr_cnt - wr0 !== int'(ewb) || rd_cnt - rd0 !== (es != 0 ? 1 : 0)) begin
            errors++;
            $display("FAIL rnd_mem: addr %h writes %0d reads %0d, required %0d %0d",
                     addr, wr_cnt - wr0, rd_cnt - rd0, ewb, (es != 0 ? 1 : 0));
         end
         if (ewb) begin
            checks++;
            for (int w = 0; w < 4; w++) begin
               if (envmem[ev*4 + w] !== vis[ev*4 + w]) begin
                  errors++;
                  $display("FAIL rnd_wb: word %0d data %h, required %h", ev*4 + w, envmem[ev*4 + w], vis[ev*4 + w]);
               end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) envmem[i] = $urandom;
      for (int i = 0; i < 4; i++) envmem[i] = 32'(i + 1);
      test_reset();
      test_refill();
      test_hits();
      test_evict();
      test_write_miss();
      test_idle();
      test_reset_alloc();
      test_rw_both();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
